// File: rtl/mips_datapath.sv
// mips_datapath
//   Single-cycle MIPS32 datapath: PC register, 32x32 register file, sign
//   extension, ALU with a HI/LO multiply/divide unit, and the write-address,
//   ALU-B, write-back and next-PC multiplexers. The control unit drives the
//   control bundle and reads back the zero flag. Instruction and data
//   memories live outside this block.
//
// Ports
//   clock       in   1   rising-edge clock for PC, register file, HI/LO
//   reset       in   1   asynchronous active-high; clears PC, regs, HI, LO
//   instruction in   32  current instruction (imem data)
//   rd          in   32  dmem read data (load result)
//   pc          out  32  current PC (imem address)
//   alu_out     out  32  ALU result, also the dmem address
//   dmem_wd     out  32  dmem write data (rt register value)
//   rf_we       in   1   register-file write enable
//   sel_wa      in   2   write address: 00 rt, 01 rd, 10 $31, 11 rt
//   sel_alu_b   in   1   ALU B: 0 rt data, 1 sign-extended immediate
//   sel_result  in   2   write-back: 00 alu_out, 01 rd, 10 pc+4, 11 alu_out
//   sel_pc      in   2   next PC: 00 pc+4, 01 branch, 10 jump, 11 rs (JR)
//   alu_ctrl    in   4   ALU operation select
//   zero        out  1   alu_out == 0

module mips_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instruction,
    input  logic [31:0] rd,
    output logic [31:0] pc,
    output logic [31:0] alu_out,
    output logic [31:0] dmem_wd,
    input  logic        rf_we,
    input  logic [1:0]  sel_wa,
    input  logic        sel_alu_b,
    input  logic [1:0]  sel_result,
    input  logic [1:0]  sel_pc,
    input  logic [3:0]  alu_ctrl,
    output logic        zero
);

    typedef enum logic [3:0] {
        ALU_AND   = 4'b0000,
        ALU_OR    = 4'b0001,
        ALU_ADD   = 4'b0010,
        ALU_XOR   = 4'b0011,
        ALU_NOR   = 4'b0100,
        ALU_SLTU  = 4'b0101,
        ALU_SUB   = 4'b0110,
        ALU_SLT   = 4'b0111,
        ALU_SLL   = 4'b1000,
        ALU_SRL   = 4'b1001,
        ALU_SRA   = 4'b1010,
        ALU_MULTU = 4'b1011,
        ALU_DIVU  = 4'b1100,
        ALU_MFHI  = 4'b1101,
        ALU_MFLO  = 4'b1110,
        ALU_LUI   = 4'b1111
    } alu_op_e;

    typedef enum logic [1:0] {
        WA_RT  = 2'b00,
        WA_RD  = 2'b01,
        WA_RA  = 2'b10,
        WA_RT2 = 2'b11
    } wa_sel_e;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_MEM  = 2'b01,
        WB_LINK = 2'b10,
        WB_ALU2 = 2'b11
    } wb_sel_e;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10,
        PC_REG    = 2'b11
    } pc_sel_e;

    // Instruction fields
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  rd_addr;
    logic [4:0]  shamt;
    logic [31:0] imm;
    logic        unused_opcode;

    assign rs_addr       = instruction[25:21];
    assign rt_addr       = instruction[20:16];
    assign rd_addr       = instruction[15:11];
    assign shamt         = instruction[10:6];
    assign imm           = {{16{instruction[15]}}, instruction[15:0]};
    assign unused_opcode = ^instruction[31:26];

    // Register file
    logic [31:0] regs [32];
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [4:0]  wa;
    logic [31:0] wd;

    assign rs_data = (rs_addr == 5'd0) ? '0 : regs[rs_addr];
    assign rt_data = (rt_addr == 5'd0) ? '0 : regs[rt_addr];
    assign dmem_wd = rt_data;

    always_comb begin
        wa = rt_addr;
        unique case (wa_sel_e'(sel_wa))
            WA_RT:   wa = rt_addr;
            WA_RD:   wa = rd_addr;
            WA_RA:   wa = 5'd31;
            WA_RT2:  wa = rt_addr;
            default: wa = rt_addr;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (rf_we && (wa != 5'd0)) begin
            regs[wa] <= wd;
        end
    end

    // ALU
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] product;
    alu_op_e     op;

    assign alu_a   = rs_data;
    assign alu_b   = sel_alu_b ? imm : rt_data;
    assign op      = alu_op_e'(alu_ctrl);
    assign product = {32'h0, alu_a} * {32'h0, alu_b};

    always_comb begin
        alu_out = '0;
        unique case (op)
            ALU_AND:   alu_out = alu_a & alu_b;
            ALU_OR:    alu_out = alu_a | alu_b;
            ALU_ADD:   alu_out = alu_a + alu_b;
            ALU_XOR:   alu_out = alu_a ^ alu_b;
            ALU_NOR:   alu_out = ~(alu_a | alu_b);
            ALU_SLTU:  alu_out = {31'h0, (alu_a < alu_b)};
            ALU_SUB:   alu_out = alu_a - alu_b;
            ALU_SLT:   alu_out = {31'h0, ($signed(alu_a) < $signed(alu_b))};
            ALU_SLL:   alu_out = alu_b << shamt;
            ALU_SRL:   alu_out = alu_b >> shamt;
            ALU_SRA:   alu_out = 32'($signed(alu_b) >>> shamt);
            ALU_MULTU: alu_out = '0;
            ALU_DIVU:  alu_out = '0;
            ALU_MFHI:  alu_out = hi;
            ALU_MFLO:  alu_out = lo;
            ALU_LUI:   alu_out = alu_b << 16;
            default:   alu_out = '0;
        endcase
    end

    assign zero = (alu_out == 32'h0);

    // HI/LO only change on MULTU/DIVU; divide by zero leaves both untouched.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (op == ALU_MULTU) begin
            hi <= product[63:32];
            lo <= product[31:0];
        end else if ((op == ALU_DIVU) && (alu_b != 32'h0)) begin
            lo <= alu_a / alu_b;
            hi <= alu_a % alu_b;
        end
    end

    // Next PC and write-back
    logic [31:0] pc_plus4;
    logic [31:0] pc_branch;
    logic [31:0] pc_jump;
    logic [31:0] pc_next;

    assign pc_plus4  = pc + 32'd4;
    assign pc_branch = pc_plus4 + {imm[29:0], 2'b00};
    assign pc_jump   = {pc_plus4[31:28], instruction[25:0], 2'b00};

    always_comb begin
        pc_next = pc_plus4;
        unique case (pc_sel_e'(sel_pc))
            PC_SEQ:    pc_next = pc_plus4;
            PC_BRANCH: pc_next = pc_branch;
            PC_JUMP:   pc_next = pc_jump;
            PC_REG:    pc_next = rs_data;
            default:   pc_next = pc_plus4;
        endcase
    end

    always_comb begin
        wd = alu_out;
        unique case (wb_sel_e'(sel_result))
            WB_ALU:  wd = alu_out;
            WB_MEM:  wd = rd;
            WB_LINK: wd = pc_plus4;
            WB_ALU2: wd = alu_out;
            default: wd = alu_out;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_next;
        end
    end

endmodule

// File: tb/tb_mips_datapath.sv
// tb_mips_datapath
//   Self-checking bench for mips_datapath: a table of single-cycle vectors
//   followed by hand-written branch/jump/link/JR and mid-run reset sequences.
//   Expected values are queued when inputs are driven and compared when the
//   outputs are sampled, one cycle per vector.

module tb_mips_datapath;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clock;
    logic        reset;
    logic [31:0] instruction;
    logic [31:0] rd;
    logic [31:0] pc;
    logic [31:0] alu_out;
    logic [31:0] dmem_wd;
    logic        rf_we;
    logic [1:0]  sel_wa;
    logic        sel_alu_b;
    logic [1:0]  sel_result;
    logic [1:0]  sel_pc;
    logic [3:0]  alu_ctrl;
    logic        zero;

    mips_datapath #(.RESET_PC(RPC)) dut (
        .clock       (clock),
        .reset       (reset),
        .instruction (instruction),
        .rd          (rd),
        .pc          (pc),
        .alu_out     (alu_out),
        .dmem_wd     (dmem_wd),
        .rf_we       (rf_we),
        .sel_wa      (sel_wa),
        .sel_alu_b   (sel_alu_b),
        .sel_result  (sel_result),
        .sel_pc      (sel_pc),
        .alu_ctrl    (alu_ctrl),
        .zero        (zero)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] rdv;
        logic        we;
        logic [1:0]  wa;
        logic        b;
        logic [1:0]  res;
        logic [3:0]  op;
        logic [31:0] ea;
        logic [31:0] ewd;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] alu;
        logic        z;
        logic [31:0] wd;
        logic [31:0] pcv;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_pc;

    function automatic logic [31:0] itype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [15:0] im);
        return {6'h08, rs, rt, im};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rdf, input logic [4:0] sh);
        return {6'h00, rs, rt, rdf, sh, 6'h20};
    endfunction

    function automatic vec_t mk(input string n, input logic [31:0] ins, input logic [31:0] rdv,
                                input logic we, input logic [1:0] wa, input logic b,
                                input logic [1:0] res, input logic [3:0] op,
                                input logic [31:0] ea, input logic [31:0] ewd);
        vec_t t;
        t.name = n; t.ins = ins; t.rdv = rdv; t.we = we; t.wa = wa; t.b = b;
        t.res = res; t.op = op; t.ea = ea; t.ewd = ewd;
        return t;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", n, act, exp);
        end
    endtask

    // Called at a falling edge: drive, queue expectation, sample before the
    // next rising edge, then return at the following falling edge.
    task automatic apply(input vec_t t, input logic [1:0] pcs);
        exp_t e;
        instruction = t.ins;
        rd          = t.rdv;
        rf_we       = t.we;
        sel_wa      = t.wa;
        sel_alu_b   = t.b;
        sel_result  = t.res;
        sel_pc      = pcs;
        alu_ctrl    = t.op;
        e.name = t.name; e.alu = t.ea; e.z = (t.ea == 32'h0); e.wd = t.ewd; e.pcv = exp_pc;
        sb.push_back(e);
        #4;
        e = sb.pop_front();
        chk({e.name, ".alu_out"}, alu_out, e.alu);
        chk({e.name, ".zero"}, {31'h0, zero}, {31'h0, e.z});
        chk({e.name, ".dmem_wd"}, dmem_wd, e.wd);
        chk({e.name, ".pc"}, pc, e.pcv);
        @(negedge clock);
    endtask

    localparam logic [31:0] BAD = 32'hBAD0_BAD0;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, got running, expected done");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        instruction = '0; rd = BAD; rf_we = 1'b0; sel_wa = 2'b00; sel_alu_b = 1'b0;
        sel_result = 2'b00; sel_pc = 2'b00; alu_ctrl = 4'b0010;

        //      name       instr                         rd    we  wa     b   res    op     alu            wd
        vecs.push_back(mk("addi11",  itype(0, 11, 16'h0101), BAD, 1, 2'b00, 1, 2'b00, 4'h2, 32'h0000_0101, 32'h0));
        vecs.push_back(mk("addi12",  itype(0, 12, 16'h0010), BAD, 1, 2'b00, 1, 2'b00, 4'h2, 32'h0000_0010, 32'h0));
        vecs.push_back(mk("divu",    rtype(11, 12, 0, 0),    BAD, 0, 2'b00, 0, 2'b00, 4'hC, 32'h0,         32'h10));
        vecs.push_back(mk("mflo14",  rtype(0, 0, 14, 0),     BAD, 1, 2'b01, 0, 2'b00, 4'hE, 32'h10,        32'h0));
        vecs.push_back(mk("mfhi13",  rtype(0, 0, 13, 0),     BAD, 1, 2'b01, 0, 2'b00, 4'hD, 32'h1,         32'h0));
        vecs.push_back(mk("rd1413",  rtype(14, 13, 0, 0),    BAD, 0, 2'b00, 0, 2'b00, 4'h2, 32'h11,        32'h1));
        vecs.push_back(mk("addi1_0", itype(0, 1, 16'h0000),  BAD, 1, 2'b00, 1, 2'b00, 4'h2, 32'h0,         32'h0));
        vecs.push_back(mk("beq_eq",  itype(0, 1, 16'h0000),  BAD, 0, 2'b00, 0, 2'b00, 4'h6, 32'h0,         32'h0));
        vecs.push_back(mk("addi1_m", itype(0, 1, 16'hFFFF),  BAD, 1, 2'b00, 1, 2'b00, 4'h2, 32'hFFFF_FFFF, 32'h0));
        vecs.push_back(mk("beq_ne",  itype(0, 1, 16'h0000),  BAD, 0, 2'b00, 0, 2'b00, 4'h6, 32'h1,         32'hFFFF_FFFF));
        vecs.push_back(mk("slt",     rtype(1, 11, 0, 0),     BAD, 0, 2'b00, 0, 2'b00, 4'h7, 32'h1,         32'h101));
        vecs.push_back(mk("sltu",    rtype(1, 11, 0, 0),     BAD, 0, 2'b00, 0, 2'b00, 4'h5, 32'h0,         32'h101));
        vecs.push_back(mk("lui2",    itype(0, 2, 16'h8000),  BAD, 1, 2'b00, 1, 2'b00, 4'hF, 32'h8000_0000, 32'h0));
        vecs.push_back(mk("sra",     rtype(0, 2, 0, 4),      BAD, 0, 2'b00, 0, 2'b00, 4'hA, 32'hF800_0000, 32'h8000_0000));
        vecs.push_back(mk("srl",     rtype(0, 2, 0, 4),      BAD, 0, 2'b00, 0, 2'b00, 4'h9, 32'h0800_0000, 32'h8000_0000));
        vecs.push_back(mk("sll",     rtype(0, 11, 0, 4),     BAD, 0, 2'b00, 0, 2'b00, 4'h8, 32'h1010,      32'h101));
        vecs.push_back(mk("and",     rtype(1, 11, 0, 0),     BAD, 0, 2'b00, 0, 2'b00, 4'h0, 32'h101,       32'h101));
        vecs.push_back(mk("or",      rtype(11, 12, 0, 0),    BAD, 0, 2'b00, 0, 2'b00, 4'h1, 32'h111,       32'h10));
        vecs.push_back(mk("xori",    itype(11, 0, 16'h00FF), BAD, 0, 2'b00, 1, 2'b00, 4'h3, 32'h1FE,       32'h0));
        vecs.push_back(mk("nor",     rtype(11, 12, 0, 0),    BAD, 0, 2'b00, 0, 2'b00, 4'h4, 32'hFFFF_FEEE, 32'h10));
        vecs.push_back(mk("addwrap", itype(1, 0, 16'h0002),  BAD, 0, 2'b00, 1, 2'b00, 4'h2, 32'h1,         32'h0));
        vecs.push_back(mk("multu",   rtype(1, 1, 0, 0),      BAD, 0, 2'b00, 0, 2'b00, 4'hB, 32'h0,         32'hFFFF_FFFF));
        vecs.push_back(mk("mfhi_m",  rtype(0, 0, 0, 0),      BAD, 0, 2'b00, 0, 2'b00, 4'hD, 32'hFFFF_FFFE, 32'h0));
        vecs.push_back(mk("mflo_m",  rtype(0, 0, 0, 0),      BAD, 0, 2'b00, 0, 2'b00, 4'hE, 32'h1,         32'h0));
        vecs.push_back(mk("divu0",   rtype(11, 0, 0, 0),     BAD, 0, 2'b00, 0, 2'b00, 4'hC, 32'h0,         32'h0));
        vecs.push_back(mk("mfhi_d0", rtype(0, 0, 0, 0),      BAD, 0, 2'b00, 0, 2'b00, 4'hD, 32'hFFFF_FFFE, 32'h0));
        vecs.push_back(mk("mflo_d0", rtype(0, 0, 0, 0),      BAD, 0, 2'b00, 0, 2'b00, 4'hE, 32'h1,         32'h0));
        vecs.push_back(mk("addi3",   itype(0, 3, 16'h1234),  BAD, 1, 2'b00, 1, 2'b00, 4'h2, 32'h1234,      32'h0));
        vecs.push_back(mk("sw",      itype(0, 3, 16'h0008),  BAD, 0, 2'b00, 1, 2'b00, 4'h2, 32'h8,         32'h1234));
        vecs.push_back(mk("lw5",     itype(0, 5, 16'h0008),  32'hDEAD_BEEF, 1, 2'b00, 1, 2'b01, 4'h2, 32'h8, 32'h0));
        vecs.push_back(mk("rd5",     rtype(0, 5, 0, 0),      BAD, 0, 2'b00, 0, 2'b00, 4'h2, 32'hDEAD_BEEF, 32'hDEAD_BEEF));
        vecs.push_back(mk("addi0",   itype(0, 0, 16'h0007),  BAD, 1, 2'b00, 1, 2'b00, 4'h2, 32'h7,         32'h0));
        vecs.push_back(mk("rd0",     rtype(0, 0, 0, 0),      BAD, 0, 2'b00, 0, 2'b00, 4'h2, 32'h0,         32'h0));
        vecs.push_back(mk("addi6",   itype(0, 6, 16'h0055),  BAD, 1, 2'b11, 1, 2'b11, 4'h2, 32'h55,        32'h0));
        vecs.push_back(mk("rd6",     rtype(0, 6, 0, 0),      BAD, 0, 2'b00, 0, 2'b00, 4'h2, 32'h55,        32'h55));
        vecs.push_back(mk("sext",    itype(0, 0, 16'h8000),  BAD, 0, 2'b00, 1, 2'b00, 4'h2, 32'hFFFF_8000, 32'h0));

        #3;
        chk("reset.pc", pc, RPC);
        @(negedge clock);
        reset = 1'b0;
        exp_pc = RPC;

        foreach (vecs[i]) begin
            apply(vecs[i], 2'b00);
            exp_pc = exp_pc + 32'd4;
        end

        // Taken branch: imm=4 -> pc + 4 + 16
        apply(mk("br", itype(0, 0, 16'h0004), BAD, 0, 2'b00, 0, 2'b00, 4'h6, 32'h0, 32'h0), 2'b01);
        exp_pc = exp_pc + 32'd20;
        // J 0x40 -> {pc+4[31:28], 0x100}
        apply(mk("j", {6'h02, 26'h40}, BAD, 0, 2'b00, 0, 2'b00, 4'h0, 32'h0, 32'h0), 2'b10);
        exp_pc = 32'h0000_0100;
        // JAL 0x80 from 0x100 -> $31 = 0x104, pc = 0x200
        apply(mk("jal", {6'h03, 26'h80}, BAD, 1, 2'b10, 0, 2'b10, 4'h0, 32'h0, 32'h0), 2'b10);
        exp_pc = 32'h0000_0200;
        apply(mk("rd31", rtype(31, 31, 0, 0), BAD, 0, 2'b00, 0, 2'b00, 4'h2, 32'h208, 32'h104), 2'b00);
        exp_pc = 32'h0000_0204;
        // JR $31 -> 0x104
        apply(mk("jr", rtype(31, 0, 0, 0), BAD, 0, 2'b00, 0, 2'b00, 4'h0, 32'h0, 32'h0), 2'b11);
        exp_pc = 32'h0000_0104;
        apply(mk("after_jr", rtype(0, 0, 0, 0), BAD, 0, 2'b00, 0, 2'b00, 4'h2, 32'h0, 32'h0), 2'b00);

        // Mid-run asynchronous reset: state clears without waiting for an edge.
        instruction = rtype(11, 1, 0, 0);
        rf_we = 1'b0; sel_alu_b = 1'b0; sel_pc = 2'b00; alu_ctrl = 4'h2;
        #2;
        chk("pre_rst.dmem_wd", dmem_wd, 32'hFFFF_FFFF);
        reset = 1'b1;
        #1;
        chk("rst.pc", pc, RPC);
        chk("rst.rs11", alu_out, 32'h0);
        chk("rst.rt1", dmem_wd, 32'h0);
        alu_ctrl = 4'hD;
        #1;
        chk("rst.hi", alu_out, 32'h0);
        alu_ctrl = 4'hE;
        #1;
        chk("rst.lo", alu_out, 32'h0);
        @(negedge clock);
        reset = 1'b0;
        exp_pc = RPC;
        apply(mk("post_rst", rtype(3, 31, 0, 0), BAD, 0, 2'b00, 0, 2'b00, 4'h1, 32'h0, 32'h0), 2'b00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
